// File: rtl/u_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   req/we/be/adr/wdat : request fields, driven by the master
//   gnt                : request accepted this cycle
//   rvld/rdat          : read data return
interface u_lsu_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        gnt;
    logic        rvld;
    logic [31:0] rdat;

    modport master (output req, we, be, adr, wdat, input gnt, rvld, rdat);
    modport slave  (input req, we, be, adr, wdat, output gnt, rvld, rdat);
endinterface

// File: rtl/u_lsu.sv
// Load/store unit: turns the execute stage's registered word request into one
// req/gnt bus transaction, returns load data and stalls execute until done.
// Misaligned accesses and bus timeouts are aborted locally and flagged.
//   clk, rst         : clock, async active-high reset
//   lsu_a/we/wd/re   : request from execute (we != 0 wins over re)
//   lsu_stall        : hold execute request registers (combinational)
//   lsu_vld/lsu_rd   : load data pulse / held load data
//   lsu_err          : abort pulse (misaligned or timeout)
//   dbus             : data-memory bus, master side
module u_lsu #(
    parameter int TO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lsu_a,
    input  logic [3:0]  lsu_we,
    input  logic [31:0] lsu_wd,
    input  logic [3:0]  lsu_re,
    output logic        lsu_stall,
    output logic        lsu_vld,
    output logic [31:0] lsu_rd,
    output logic        lsu_err,
    u_lsu_if.master     dbus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, ABORT} state_t;

    localparam logic [9:0] TO_LAST = 10'(TO_CYC - 1);

    state_t     state;
    logic [9:0] cnt;

    logic is_st, is_req, mis, busy, timeout, st_done, ld_done;

    always_comb begin
        is_st   = |lsu_we;
        is_req  = is_st | (|lsu_re);
        mis     = |lsu_a[1:0];
        busy    = (state == REQ) || (state == WAIT);
        timeout = busy && (cnt == TO_LAST);
        st_done = (state == REQ) && dbus.gnt && dbus.we;
        ld_done = (state == WAIT) && dbus.rvld;
        // Stall drops in the completing cycle so execute can load its next
        // request on the same edge the current one retires.
        lsu_stall = !rst && (((state == IDLE) && is_req) ||
                             (busy && !timeout && !st_done && !ld_done));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lsu_vld   <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rd    <= '0;
            dbus.req  <= 1'b0;
            dbus.we   <= 1'b0;
            dbus.be   <= '0;
            dbus.adr  <= '0;
            dbus.wdat <= '0;
        end else begin
            lsu_vld <= 1'b0;
            lsu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_req) begin
                        if (mis) begin
                            // No bus access; a load still retires with zero data.
                            state   <= ABORT;
                            lsu_err <= 1'b1;
                            if (!is_st) begin
                                lsu_vld <= 1'b1;
                                lsu_rd  <= '0;
                            end
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            dbus.req  <= 1'b1;
                            dbus.we   <= is_st;
                            dbus.be   <= is_st ? lsu_we : lsu_re;
                            dbus.adr  <= {lsu_a[31:2], 2'b00};
                            dbus.wdat <= lsu_wd;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 10'd1;
                    // Timeout takes priority so the counter can never run past
                    // its terminal value while still busy.
                    if (timeout) begin
                        state    <= ABORT;
                        dbus.req <= 1'b0;
                        lsu_err  <= 1'b1;
                        if (!dbus.we) begin
                            lsu_vld <= 1'b1;
                            lsu_rd  <= '0;
                        end
                    end else if (state == REQ) begin
                        if (dbus.gnt) begin
                            dbus.req <= 1'b0;
                            state    <= dbus.we ? IDLE : WAIT;
                        end
                    end else if (dbus.rvld) begin
                        lsu_rd  <= dbus.rdat;
                        lsu_vld <= 1'b1;
                        state   <= IDLE;
                    end
                end
                ABORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_u_lsu.sv
// Bench for u_lsu: directed vectors; bus transactions, load returns and
// aborts are predicted into queues and checked by an independent monitor.
// A second instance with TO_CYC=4 and a silent bus covers the timeout path.
module tb_u_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, wd = '0;
    logic [3:0]  we = '0, re = '0;
    logic        stall, vld, err;
    logic [31:0] rd;

    logic [31:0] t_a = '0, t_wd = '0;
    logic [3:0]  t_we = '0, t_re = '0;
    logic        t_stall, t_vld, t_err;
    logic [31:0] t_rd;

    u_lsu_if bi();
    u_lsu_if bt();

    u_lsu dut (
        .clk(clk), .rst(rst), .lsu_a(a), .lsu_we(we), .lsu_wd(wd), .lsu_re(re),
        .lsu_stall(stall), .lsu_vld(vld), .lsu_rd(rd), .lsu_err(err), .dbus(bi.master)
    );

    u_lsu #(.TO_CYC(4)) dut_to (
        .clk(clk), .rst(rst), .lsu_a(t_a), .lsu_we(t_we), .lsu_wd(t_wd), .lsu_re(t_re),
        .lsu_stall(t_stall), .lsu_vld(t_vld), .lsu_rd(t_rd), .lsu_err(t_err), .dbus(bt.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] wdat;
    } bus_t;

    bus_t        q_bus[$];
    logic [31:0] q_rd[$];
    bit          q_err[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event, got 1 want 0", nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted bus request, load return and abort must match
    // the next predicted entry of its kind.
    always @(negedge clk) begin
        if (!rst) begin
            if (bi.req && bi.gnt) begin
                if (q_bus.size() == 0) unexp("bus");
                else chk("bus", {bi.we, bi.be, bi.adr, bi.wdat}, q_bus.pop_front());
            end
            if (vld) begin
                if (q_rd.size() == 0) unexp("rd");
                else chk("rd", rd, q_rd.pop_front());
            end
            if (err) begin
                if (q_err.size() == 0) unexp("err");
                else void'(q_err.pop_front());
            end
        end
    end

    initial begin
        bi.gnt = 0; bi.rvld = 0; bi.rdat = '0;
        bt.gnt = 0; bt.rvld = 0; bt.rdat = '0;

        // Reset state
        @(negedge clk);
        chk("rst_req", bi.req, 0);   chk("rst_stall", stall, 0);
        chk("rst_vld", vld, 0);      chk("rst_err", err, 0);
        chk("rst_rd", rd, 0);        chk("rst_fields", {bi.we, bi.be, bi.adr, bi.wdat}, 0);
        tick; rst = 0;

        // Store with gnt held low for 3 REQ cycles
        a = 32'h100; we = 4'hF; wd = 32'hCAFEF00D;
        q_bus.push_back('{1'b1, 4'hF, 32'h100, 32'hCAFEF00D});
        @(negedge clk); chk("st_c0_stall", stall, 1); chk("st_c0_req", bi.req, 0);
        for (int i = 0; i < 4; i++) begin
            tick; if (i == 3) bi.gnt = 1;
            @(negedge clk);
            chk("st_req", bi.req, 1);
            chk("st_fields", {bi.we, bi.be, bi.adr, bi.wdat}, {1'b1, 4'hF, 32'h100, 32'hCAFEF00D});
            chk("st_stall", stall, (i == 3) ? 1'b0 : 1'b1);
        end
        tick; bi.gnt = 0; we = 0;
        @(negedge clk); chk("st_done_req", bi.req, 0); chk("st_done_stall", stall, 0);

        // Load, gnt immediate, rvld two cycles after gnt
        tick; a = 32'h204; re = 4'hF; wd = 0;
        q_bus.push_back('{1'b0, 4'hF, 32'h204, 32'h0});
        q_rd.push_back(32'h12345678);
        @(negedge clk); chk("ld_c0_stall", stall, 1);
        tick; bi.gnt = 1;
        @(negedge clk); chk("ld_c1_req", bi.req, 1); chk("ld_c1_stall", stall, 1);
        tick; bi.gnt = 0;
        @(negedge clk); chk("ld_c2_req", bi.req, 0); chk("ld_c2_stall", stall, 1);
        tick; bi.rvld = 1; bi.rdat = 32'h12345678;
        @(negedge clk); chk("ld_c3_stall", stall, 0); chk("ld_c3_vld", vld, 0);
        tick; bi.rvld = 0; bi.rdat = 32'hDEADBEEF; re = 0;
        @(negedge clk); chk("ld_c4_vld", vld, 1);
        tick;
        @(negedge clk); chk("ld_c5_vld", vld, 0); chk("ld_hold_rd", rd, 32'h12345678);

        // Store then load back-to-back, gnt held high, rvld immediate
        tick; a = 32'h300; we = 4'h3; wd = 32'h0000BEEF; bi.gnt = 1;
        q_bus.push_back('{1'b1, 4'h3, 32'h300, 32'h0000BEEF});
        @(negedge clk); chk("bb_c0_stall", stall, 1); chk("bb_c0_req", bi.req, 0);
        tick;
        @(negedge clk); chk("bb_c1_req", bi.req, 1); chk("bb_c1_stall", stall, 0);
        tick; a = 32'h304; we = 0; re = 4'hC;
        q_bus.push_back('{1'b0, 4'hC, 32'h304, 32'h0000BEEF});
        q_rd.push_back(32'hA5A5A5A5);
        @(negedge clk); chk("bb_c2_req", bi.req, 0); chk("bb_c2_stall", stall, 1);
        tick;
        @(negedge clk); chk("bb_c3_req", bi.req, 1); chk("bb_c3_we", bi.we, 0);
        tick; bi.rvld = 1; bi.rdat = 32'hA5A5A5A5;
        @(negedge clk); chk("bb_c4_req", bi.req, 0); chk("bb_c4_stall", stall, 0);
        tick; bi.rvld = 0; bi.gnt = 0; re = 0;
        @(negedge clk); chk("bb_c5_vld", vld, 1);

        // Reset while in WAIT
        tick; a = 32'h400; re = 4'hF;
        q_bus.push_back('{1'b0, 4'hF, 32'h400, 32'h0000BEEF});
        tick; bi.gnt = 1;
        tick; bi.gnt = 0;
        @(negedge clk); chk("rw_wait_stall", stall, 1);
        #2 rst = 1;
        #1;
        chk("rw_req", bi.req, 0); chk("rw_vld", vld, 0); chk("rw_err", err, 0);
        chk("rw_rd", rd, 0);      chk("rw_stall", stall, 0);
        chk("rw_fields", {bi.we, bi.be, bi.adr, bi.wdat}, 0);
        tick; rst = 0; re = 0; bi.rvld = 1; bi.rdat = 32'hFFFFFFFF;
        tick; bi.rvld = 0;
        @(negedge clk); chk("rw_stray_vld", vld, 0); chk("rw_stray_req", bi.req, 0);
        tick; a = 32'h500; re = 4'hF; wd = 0;
        q_bus.push_back('{1'b0, 4'hF, 32'h500, 32'h0});
        q_rd.push_back(32'h55AA55AA);
        tick; bi.gnt = 1;
        tick; bi.gnt = 0; bi.rvld = 1; bi.rdat = 32'h55AA55AA;
        tick; bi.rvld = 0; re = 0;
        @(negedge clk); chk("rw_next_vld", vld, 1);

        // Misaligned load: no bus traffic, err and vld together with rd=0
        tick; a = 32'h102; re = 4'hF;
        q_rd.push_back(32'h0);
        q_err.push_back(1'b1);
        @(negedge clk); chk("ma_c0_stall", stall, 1); chk("ma_c0_req", bi.req, 0);
        tick; re = 0;
        @(negedge clk);
        chk("ma_c1_req", bi.req, 0); chk("ma_c1_err", err, 1); chk("ma_c1_vld", vld, 1);
        chk("ma_c1_rd", rd, 0);      chk("ma_c1_stall", stall, 0);
        tick;
        @(negedge clk); chk("ma_c2_err", err, 0); chk("ma_c2_req", bi.req, 0);

        // Timeout (TO_CYC=4), gnt never asserted
        tick; t_a = 32'h600; t_re = 4'hF;
        @(negedge clk); chk("to_c0_stall", t_stall, 1);
        for (int i = 1; i <= 4; i++) begin
            tick;
            @(negedge clk);
            chk("to_req", bt.req, 1);
            chk("to_stall", t_stall, (i == 4) ? 1'b0 : 1'b1);
            chk("to_err_early", t_err, 0);
        end
        tick; t_re = 0;
        @(negedge clk);
        chk("to_req_drop", bt.req, 0); chk("to_err", t_err, 1); chk("to_vld", t_vld, 1);
        chk("to_rd", t_rd, 0);         chk("to_abort_stall", t_stall, 0);
        tick;
        @(negedge clk); chk("to_err_end", t_err, 0); chk("to_vld_end", t_vld, 0);
        chk("to_idle_stall", t_stall, 0);

        tick;
        chk("q_bus_left", q_bus.size(), 0);
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_err_left", q_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
